// File: rtl/uart_cfg_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cfg_cmd_ctrl
// Brief    : Decodes UART command frames (opcode + data) into config registers.
// Revision : 1.0
// ============================================================================
module uart_cfg_cmd_ctrl #(
    parameter logic [19:0] TIMEOUT  = 20'd1000000,
    parameter logic [15:0] BAUD_RST = 16'd434,
    parameter logic [15:0] BAUD_MIN = 16'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    output logic [15:0] baud,
    output logic [7:0]  match,
    output logic [7:0]  mask,
    output logic        trig_en,
    output logic        cfg_done,
    output logic        cfg_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPC_CHK = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    localparam logic [7:0] C_OPC_BAUD  = 8'h01;
    localparam logic [7:0] C_OPC_MATCH = 8'h02;
    localparam logic [7:0] C_OPC_MASK  = 8'h03;
    localparam logic [7:0] C_OPC_TRIG  = 8'h04;

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] staging_q, staging_d;
    logic [19:0] tmo_cnt_q, tmo_cnt_d;
    logic        clr_rdy_q, clr_rdy_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  match_q, match_d;
    logic [7:0]  mask_q, mask_d;
    logic        trig_en_q, trig_en_d;

    logic w_in_data;
    logic w_timeout_hit;
    logic w_accept;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        staging_d = staging_q;
        tmo_cnt_d = tmo_cnt_q;
        baud_d    = baud_q;
        match_d   = match_q;
        mask_d    = mask_q;
        trig_en_d = trig_en_q;
        cfg_done  = 1'b0;
        cfg_err   = 1'b0;

        w_in_data     = (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO);
        w_timeout_hit = w_in_data && (tmo_cnt_q >= TIMEOUT);
        // A byte that shows up on the timeout cycle is left pending for IDLE.
        w_accept      = rdy && !clr_rdy_q && !w_timeout_hit;
        clr_rdy_d     = w_accept;

        if (w_accept) begin
            tmo_cnt_d = 20'd0;
        end else if (w_in_data && (tmo_cnt_q < TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + 20'd1;
        end

        case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = 20'd0;
                if (w_accept) begin
                    opcode_d  = rx_data;
                    staging_d = 16'd0;
                    state_d   = ST_OPC_CHK;
                end
            end
            ST_OPC_CHK: begin
                if (opcode_q == C_OPC_BAUD) begin
                    state_d = ST_DATA_HI;
                end else if ((opcode_q == C_OPC_MATCH) || (opcode_q == C_OPC_MASK) ||
                             (opcode_q == C_OPC_TRIG)) begin
                    state_d = ST_DATA_LO;
                end else begin
                    cfg_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA_HI: begin
                if (w_timeout_hit) begin
                    cfg_err   = 1'b1;
                    staging_d = 16'd0;
                    state_d   = ST_IDLE;
                end else if (w_accept) begin
                    staging_d[15:8] = rx_data;
                    state_d         = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (w_timeout_hit) begin
                    cfg_err   = 1'b1;
                    staging_d = 16'd0;
                    state_d   = ST_IDLE;
                end else if (w_accept) begin
                    staging_d[7:0] = rx_data;
                    state_d        = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                case (opcode_q)
                    C_OPC_BAUD: begin
                        if (staging_q < BAUD_MIN) begin
                            cfg_err = 1'b1;
                        end else begin
                            baud_d   = staging_q;
                            cfg_done = 1'b1;
                        end
                    end
                    C_OPC_MATCH: begin
                        match_d  = staging_q[7:0];
                        cfg_done = 1'b1;
                    end
                    C_OPC_MASK: begin
                        mask_d   = staging_q[7:0];
                        cfg_done = 1'b1;
                    end
                    default: begin
                        trig_en_d = staging_q[0];
                        cfg_done  = 1'b1;
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 8'd0;
            staging_q <= 16'd0;
            tmo_cnt_q <= 20'd0;
            clr_rdy_q <= 1'b0;
            baud_q    <= BAUD_RST;
            match_q   <= 8'h00;
            mask_q    <= 8'hFF;
            trig_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            staging_q <= staging_d;
            tmo_cnt_q <= tmo_cnt_d;
            clr_rdy_q <= clr_rdy_d;
            baud_q    <= baud_d;
            match_q   <= match_d;
            mask_q    <= mask_d;
            trig_en_q <= trig_en_d;
        end
    end

    assign clr_rdy = clr_rdy_q;
    assign baud    = baud_q;
    assign match   = match_q;
    assign mask    = mask_q;
    assign trig_en = trig_en_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cfg_cmd_ctrl
// Brief    : Directed frames with a pulse scoreboard for uart_cfg_cmd_ctrl.
// Revision : 1.0
// ============================================================================
module tb_uart_cfg_cmd_ctrl;

    localparam int TMO = 40;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic [7:0]  rx_data;
    logic        clr_rdy;
    logic [15:0] baud;
    logic [7:0]  match;
    logic [7:0]  mask;
    logic        trig_en;
    logic        cfg_done;
    logic        cfg_err;

    uart_cfg_cmd_ctrl #(
        .TIMEOUT  (20'(TMO)),
        .BAUD_RST (16'd434),
        .BAUD_MIN (16'd16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy),
        .rx_data  (rx_data),
        .clr_rdy  (clr_rdy),
        .baud     (baud),
        .match    (match),
        .mask     (mask),
        .trig_en  (trig_en),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    typedef struct packed {
        logic        err;
        logic [15:0] baud;
        logic [7:0]  match;
        logic [7:0]  mask;
        logic        trig;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   clr_cnt = 0;

    logic [15:0] m_baud;
    logic [7:0]  m_match;
    logic [7:0]  m_mask;
    logic        m_trig;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic push_exp(input logic err);
        exp_t e;
        e.err   = err;
        e.baud  = m_baud;
        e.match = m_match;
        e.mask  = m_mask;
        e.trig  = m_trig;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_baud  = 16'd434;
        m_match = 8'h00;
        m_mask  = 8'hFF;
        m_trig  = 1'b0;
    endtask

    // Receiver model: raise rdy, drop it on the cycle clr_rdy is seen.
    task automatic send_byte(input logic [7:0] b);
        int k;
        rdy     = 1'b1;
        rx_data = b;
        k       = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!clr_rdy && k < 20);
        chk("byte_consumed", {31'd0, clr_rdy}, 32'd1);
        rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (clr_rdy) clr_cnt++;
        end
    end

    // Scoreboard monitor: pops one expectation per cfg_done/cfg_err pulse.
    initial begin
        exp_t pend;
        logic pending;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                chk("post_baud",  {16'd0, baud},    {16'd0, pend.baud});
                chk("post_match", {24'd0, match},   {24'd0, pend.match});
                chk("post_mask",  {24'd0, mask},    {24'd0, pend.mask});
                chk("post_trig",  {31'd0, trig_en}, {31'd0, pend.trig});
                pending = 1'b0;
            end
            if (cfg_done || cfg_err) begin
                chk("done_err_exclusive", {31'd0, cfg_done && cfg_err}, 32'd0);
                chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    pend = exp_q.pop_front();
                    chk("pulse_kind_err", {31'd0, cfg_err}, {31'd0, pend.err});
                    pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k;
        rst_n   = 1'b0;
        rdy     = 1'b0;
        rx_data = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_baud",    {16'd0, baud},     32'd434);
        chk("rst_match",   {24'd0, match},    32'h00);
        chk("rst_mask",    {24'd0, mask},     32'hFF);
        chk("rst_trig",    {31'd0, trig_en},  32'd0);
        chk("rst_clr_rdy", {31'd0, clr_rdy},  32'd0);
        chk("rst_done",    {31'd0, cfg_done}, 32'd0);
        chk("rst_err",     {31'd0, cfg_err},  32'd0);

        // Baud write: three bytes, three clr_rdy pulses
        c0     = clr_cnt;
        m_baud = 16'h006C;
        push_exp(1'b0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h6C);
        repeat (3) @(negedge clk);
        chk("baud_clr_pulses", clr_cnt - c0, 32'd3);

        m_match = 8'hA5;
        push_exp(1'b0);
        send_byte(8'h02);
        send_byte(8'hA5);
        m_mask = 8'h0F;
        push_exp(1'b0);
        send_byte(8'h03);
        send_byte(8'h0F);

        // Unknown opcode leaves everything untouched
        push_exp(1'b1);
        send_byte(8'h07);
        repeat (2) @(negedge clk);
        m_trig = 1'b1;
        push_exp(1'b0);
        send_byte(8'h04);
        send_byte(8'h01);

        // Baud below minimum rejected, exactly-minimum accepted
        push_exp(1'b1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h08);
        repeat (2) @(negedge clk);
        m_baud = 16'h0010;
        push_exp(1'b0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (2) @(negedge clk);

        // Timeout; a byte raised on the timeout cycle becomes the next opcode
        push_exp(1'b1);
        send_byte(8'h01);
        k = 1;
        while (!cfg_err && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_latency", k, TMO + 1);
        rdy     = 1'b1;
        rx_data = 8'h02;
        m_match = 8'h3C;
        push_exp(1'b0);
        @(negedge clk);
        chk("timeout_wins_no_accept", {31'd0, clr_rdy}, 32'd0);
        k = 0;
        while (!clr_rdy && k < 5) begin
            @(negedge clk);
            k++;
        end
        chk("late_byte_consumed", {31'd0, clr_rdy}, 32'd1);
        rdy = 1'b0;
        @(negedge clk);
        send_byte(8'h3C);
        repeat (2) @(negedge clk);

        // Reset mid-frame discards the frame silently
        send_byte(8'h01);
        send_byte(8'h12);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_baud",  {16'd0, baud},    32'd434);
        chk("midrst_match", {24'd0, match},   32'h00);
        chk("midrst_mask",  {24'd0, mask},    32'hFF);
        chk("midrst_trig",  {31'd0, trig_en}, 32'd0);
        m_mask = 8'h55;
        push_exp(1'b0);
        send_byte(8'h03);
        send_byte(8'h55);

        repeat (5) @(negedge clk);
        chk("all_pulses_seen", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
